// File: rtl/vppm_pkg.sv
// Shared types and helpers for the VPPM transmitter.
// Parity support is compiled in with VPPM_TX_PARITY_EN.
package vppm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SYNC,
    DATA,
    PARITY
  } vppm_tx_state_t;

  localparam int VPPM_MIN_PREAMBLE = 5;
  localparam int VPPM_MAX_DATA_W   = 64;

  // Zero-extension does not change the XOR, so narrower words pass through a cast.
  function automatic logic evenParity(input logic [VPPM_MAX_DATA_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/vppm_bit_timer.sv
// Half-bit timer: counts H cycles per half and flags the last cycle of each bit.
// halfNext is the value halfSel takes after the coming edge.
module vppm_bit_timer #(
  parameter int HP_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [HP_W-1:0] halfCycles,
  output logic            halfSel,
  output logic            halfNext,
  output logic            bitEnd
);

  logic [HP_W-1:0] cycleCnt;
  logic            halfEnd;

  // halfCycles is never 0: the top level maps 0 to 1 when it latches H.
  assign halfEnd  = (cycleCnt == halfCycles - HP_W'(1));
  assign bitEnd   = halfSel & halfEnd;
  assign halfNext = load ? 1'b0 : (halfSel ^ halfEnd);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycleCnt <= '0;
      halfSel  <= 1'b0;
    end else begin
      halfSel <= halfNext;
      if (load || halfEnd) cycleCnt <= '0;
      else                 cycleCnt <= cycleCnt + HP_W'(1);
    end
  end

endmodule

// File: rtl/vppm_tx.sv
// VPPM transmitter: preamble of zero bits, one sync zero bit, then MSB-first words
// from a valid/ready source. Optional even-parity bit per word with VPPM_TX_PARITY_EN.
module vppm_tx
  import vppm_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int PREAMBLE_BITS = 5,
  parameter int HP_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HP_W-1:0]   halfPeriod,
  input  logic              start,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              dataValid,
  output logic              dataReady,
  output logic              vppmOut,
  output logic              busy,
  output logic              wordDone
);

  localparam int CNT_MAX = (PREAMBLE_BITS > DATA_W + 1) ? PREAMBLE_BITS : DATA_W + 1;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  if (PREAMBLE_BITS < VPPM_MIN_PREAMBLE) begin : gPreambleCheck
    $error("vppm_tx: PREAMBLE_BITS must be at least VPPM_MIN_PREAMBLE");
  end

  vppm_tx_state_t    state, stateNext;
  logic [CNT_W-1:0]  bitCnt, bitCntNext;
  logic [DATA_W-1:0] shiftReg, shiftNext;
  logic [HP_W-1:0]   hReg, hNext;
  logic              starting, startingNext;
  logic              halfSel, halfNext, bitEnd;
  logic              bitNext, vppmNext;
`ifdef VPPM_TX_PARITY_EN
  logic              parityReg, parityNext;
`endif

  // 'starting' is the one cycle between accepting start and the first preamble cycle;
  // the timer restarts then so the frame begins on a clean first half.
  vppm_bit_timer #(.HP_W(HP_W)) uTimer (
    .clk       (clk),
    .rst       (rst),
    .load      (starting),
    .halfCycles(hReg),
    .halfSel   (halfSel),
    .halfNext  (halfNext),
    .bitEnd    (bitEnd)
  );

`ifdef VPPM_TX_PARITY_EN
  assign wordDone = bitEnd && (state == PARITY);
`else
  assign wordDone = bitEnd && (state == DATA) && (bitCnt == DATA_LAST);
`endif
  assign dataReady = wordDone || (bitEnd && (state == SYNC));
  assign busy      = (state != IDLE);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext    = state;
    bitCntNext   = bitCnt;
    shiftNext    = shiftReg;
    hNext        = hReg;
    startingNext = 1'b0;
`ifdef VPPM_TX_PARITY_EN
    parityNext   = parityReg;
`endif

    case (state)
      IDLE: begin
        if (starting) begin
          stateNext  = PREAMBLE;
          bitCntNext = '0;
        end else if (start) begin
          hNext        = (halfPeriod == '0) ? HP_W'(1) : halfPeriod;
          startingNext = 1'b1;
        end
      end
      PREAMBLE: begin
        if (bitEnd) begin
          if (bitCnt == PRE_LAST) begin
            stateNext  = SYNC;
            bitCntNext = '0;
          end else begin
            bitCntNext = bitCnt + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (bitEnd) begin
          if (bitCnt != DATA_LAST) begin
            shiftNext  = shiftReg << 1;
            bitCntNext = bitCnt + CNT_W'(1);
          end
`ifdef VPPM_TX_PARITY_EN
          else begin
            stateNext = PARITY;
          end
`endif
        end
      end
      default: ;
    endcase

    // Word boundary: load the next word with no gap, or close the frame.
    if (dataReady) begin
      if (dataValid) begin
        stateNext  = DATA;
        shiftNext  = dataIn;
        bitCntNext = '0;
`ifdef VPPM_TX_PARITY_EN
        parityNext = evenParity(VPPM_MAX_DATA_W'(dataIn));
`endif
      end else begin
        stateNext = IDLE;
      end
    end

    case (stateNext)
      DATA:    bitNext = shiftNext[DATA_W-1];
`ifdef VPPM_TX_PARITY_EN
      PARITY:  bitNext = parityNext;
`endif
      default: bitNext = 1'b0;
    endcase
    vppmNext = (stateNext != IDLE) & ~(halfNext ^ bitNext);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bitCnt   <= '0;
      shiftReg <= '0;
      hReg     <= HP_W'(1);
      starting <= 1'b0;
      vppmOut  <= 1'b0;
`ifdef VPPM_TX_PARITY_EN
      parityReg <= 1'b0;
`endif
    end else begin
      state    <= stateNext;
      bitCnt   <= bitCntNext;
      shiftReg <= shiftNext;
      hReg     <= hNext;
      starting <= startingNext;
      vppmOut  <= vppmNext;
`ifdef VPPM_TX_PARITY_EN
      parityReg <= parityNext;
`endif
    end
  end

endmodule

// File: tb/tb_vppm_tx.sv
// Self-checking bench for vppm_tx: each frame is predicted from the bit list it should carry.
// Honours VPPM_TX_PARITY_EN in the reference model.
module tb_vppm_tx;

  localparam int DATA_W = 8;
  localparam int PRE    = 5;
  localparam int HP_W   = 32;
`ifdef VPPM_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [HP_W-1:0]   halfPeriod;
  logic              start;
  logic [DATA_W-1:0] dataIn;
  logic              dataValid;
  logic              dataReady, vppmOut, busy, wordDone;

  int passCount  = 0;
  int checkCount = 0;
  logic [DATA_W-1:0] wordQ[$];

  always #5 clk = ~clk;

  vppm_tx #(.DATA_W(DATA_W), .PREAMBLE_BITS(PRE), .HP_W(HP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .halfPeriod(halfPeriod),
    .start     (start),
    .dataIn    (dataIn),
    .dataValid (dataValid),
    .dataReady (dataReady),
    .vppmOut   (vppmOut),
    .busy      (busy),
    .wordDone  (wordDone)
  );

  // Starts a frame in the current cycle (called at a negedge), feeds wordQ as a
  // valid/ready source, and checks every output cycle against the expected symbol train.
  task automatic run_frame(input int hp, input bit disturb, input string name);
    int h, nWords, total, idx, pos;
    int vErr, rErr, dErr, bErr, firstV, busyCnt, wdCnt;
    bit bits[$];
    bit rdyAt[$];
    bit doneAt[$];
    bit popPending;
    logic expV, expR, expD, expB;
    logic [DATA_W-1:0] w;

    h = (hp == 0) ? 1 : hp;
    nWords = wordQ.size();
    for (int i = 0; i <= PRE; i++) begin
      bits.push_back(1'b0); rdyAt.push_back(i == PRE); doneAt.push_back(1'b0);
    end
    foreach (wordQ[j]) begin
      w = wordQ[j];
      for (int i = DATA_W - 1; i >= 0; i--) begin
        bits.push_back(w[i]);
        rdyAt.push_back(PAR == 0 && i == 0);
        doneAt.push_back(PAR == 0 && i == 0);
      end
      if (PAR == 1) begin
        bits.push_back(^w); rdyAt.push_back(1'b1); doneAt.push_back(1'b1);
      end
    end
    total = bits.size() * 2 * h;

    halfPeriod = HP_W'(hp);
    start      = 1'b1;
    dataValid  = (wordQ.size() > 0);
    dataIn     = dataValid ? wordQ[0] : '0;
    @(negedge clk);
    start = 1'b0;
    checkCount++;
    if (busy !== 1'b0 || vppmOut !== 1'b0)
      $display("FAIL %s latency: busy=%b vppmOut=%b one cycle after start, required 0/0", name, busy, vppmOut);
    else passCount++;

    vErr = 0; rErr = 0; dErr = 0; bErr = 0; firstV = 0; busyCnt = 0; wdCnt = 0; popPending = 0;
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      start = disturb && (k == 20);
      if (disturb && k == 20) halfPeriod = HP_W'(7);
      if (popPending) begin
        void'(wordQ.pop_front());
        popPending = 0;
      end
      dataValid = (wordQ.size() > 0);
      dataIn    = dataValid ? wordQ[0] : '0;
      if (k <= total) begin
        idx  = (k - 1) / (2 * h);
        pos  = (k - 1) % (2 * h);
        expV = (pos < h) ? !bits[idx] : bits[idx];
        expR = (pos == 2 * h - 1) && rdyAt[idx];
        expD = (pos == 2 * h - 1) && doneAt[idx];
        expB = 1'b1;
      end else begin
        expV = 1'b0; expR = 1'b0; expD = 1'b0; expB = 1'b0;
      end
      if (vppmOut !== expV) begin
        if (vErr == 0) firstV = k;
        vErr++;
      end
      if (dataReady !== expR) rErr++;
      if (wordDone !== expD) dErr++;
      if (busy !== expB) bErr++;
      if (dataReady === 1'b1 && dataValid) popPending = 1;
      if (busy === 1'b1) busyCnt++;
      if (wordDone === 1'b1) wdCnt++;
    end
    start = 1'b0;
    dataValid = 1'b0;

    checkCount++;
    if (vErr != 0) $display("FAIL %s vppmOut: %0d wrong cycles (first at cycle %0d), required 0", name, vErr, firstV);
    else passCount++;
    checkCount++;
    if (rErr != 0) $display("FAIL %s dataReady: %0d wrong cycles, required 0", name, rErr);
    else passCount++;
    checkCount++;
    if (dErr != 0 || wdCnt != nWords)
      $display("FAIL %s wordDone: %0d wrong cycles, %0d pulses, required 0 wrong and %0d pulses", name, dErr, wdCnt, nWords);
    else passCount++;
    checkCount++;
    if (bErr != 0 || busyCnt != total)
      $display("FAIL %s busy/length: %0d busy cycles (%0d wrong), required %0d", name, busyCnt, bErr, total);
    else passCount++;
    checkCount++;
    if (wordQ.size() != 0) $display("FAIL %s accept: %0d words left unsent, required 0", name, wordQ.size());
    else passCount++;
    wordQ.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dataValid = 1'b0; dataIn = '0; halfPeriod = HP_W'(4);
    repeat (3) @(negedge clk);
    checkCount++;
    if ({vppmOut, busy, dataReady, wordDone} !== 4'b0000)
      $display("FAIL reset outputs: vppmOut/busy/dataReady/wordDone=%b, required 0000",
               {vppmOut, busy, dataReady, wordDone});
    else passCount++;
    rst = 1'b0;
    @(negedge clk);
    checkCount++;
    if ({vppmOut, busy} !== 2'b00) $display("FAIL reset idle: vppmOut/busy=%b, required 00", {vppmOut, busy});
    else passCount++;
  endtask

  task automatic test_preamble_only();
    run_frame(4, 1'b0, "preamble_only");
  endtask

  task automatic test_two_words();
    wordQ = '{8'hA5, 8'h3C};
    run_frame(4, 1'b0, "two_words");
  endtask

  task automatic test_half_period_zero();
    run_frame(0, 1'b0, "half_period_zero");
  endtask

  task automatic test_mid_frame_ignore();
    wordQ = '{8'h5A};
    run_frame(4, 1'b1, "mid_frame_ignore");
  endtask

  task automatic test_parity_word();
    wordQ = '{8'hA5};
    run_frame(4, 1'b0, "single_word_parity");
  endtask

  task automatic test_back_to_back();
    wordQ = '{8'hFF};
    run_frame(3, 1'b0, "back_to_back_a");
    wordQ = '{8'h00, 8'h81};
    run_frame(2, 1'b0, "back_to_back_b");
  endtask

  task automatic test_rst_mid_frame();
    int k;
    logic [DATA_W-1:0] w;
    w = 8'hA5;
    k = (PRE + 1 + 3) * 2 * 4 + 3;
    halfPeriod = HP_W'(4); dataIn = w; dataValid = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (k) @(negedge clk);
    checkCount++;
    if (vppmOut !== !w[DATA_W-1-3]) $display("FAIL rst_mid pre: vppmOut=%b in data bit 3, required %b", vppmOut, !w[DATA_W-1-3]);
    else passCount++;
    rst = 1'b1; dataValid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkCount++;
    if ({vppmOut, busy, dataReady} !== 3'b000)
      $display("FAIL rst_mid post: vppmOut/busy/dataReady=%b, required 000", {vppmOut, busy, dataReady});
    else passCount++;
    run_frame(4, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    int nw;
    for (int f = 0; f < 8; f++) begin
      nw = $urandom_range(0, 3);
      for (int i = 0; i < nw; i++) wordQ.push_back(DATA_W'($urandom));
      run_frame($urandom_range(0, 5), 1'b0, $sformatf("random_%0d", f));
    end
  endtask

  initial begin
    test_reset();
    test_preamble_only();
    test_two_words();
    test_half_period_zero();
    test_mid_frame_ignore();
    test_parity_word();
    test_back_to_back();
    test_rst_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
